// File: rtl/vco_adc_decim_datapath.sv
// rtl/vco_adc_decim_datapath.sv - VCO ADC channel: counter differencing, P-N difference, boxcar decimator
module vco_adc_decim_datapath #(
    parameter int N_BITS_ACC_EXT = 3
) (
    input  logic              CLK_24M,
    input  logic              reset,
    input  logic              enable_sampling_3M,
    input  logic        [8:0] counter_p,
    input  logic        [8:0] counter_n,
    output logic signed [8:0] channel_output
);

    localparam int ACC_W = 10 + N_BITS_ACC_EXT;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] OUT_MIN = -ACC_W'(256);

    logic        [8:0]       prev_p;
    logic        [8:0]       prev_n;
    logic signed [ACC_W-1:0] acc;

    logic        [8:0]       d_p;
    logic        [8:0]       d_n;
    logic signed [9:0]       diff;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] sum_sat;
    logic signed [8:0]       out_sat;

    // First differences (mod-512 subtraction absorbs counter wrap), P-N difference,
    // saturating accumulate and the final clamp to the 9-bit output range
    always_comb begin
        d_p      = counter_p - prev_p;
        d_n      = counter_n - prev_n;
        diff     = $signed({1'b0, d_p}) - $signed({1'b0, d_n});
        sum_wide = $signed({acc[ACC_W-1], acc})
                 + $signed({{(ACC_W+1-10){diff[9]}}, diff});

        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_W-1:0];
        end

        if (sum_sat > OUT_MAX) begin
            out_sat = 9'sd255;
        end else if (sum_sat < OUT_MIN) begin
            out_sat = -9'sd256;
        end else begin
            out_sat = sum_sat[8:0];
        end
    end

    // Track previous counter values; integrate diffs and dump to the output on each strobe
    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            prev_p         <= counter_p;
            prev_n         <= counter_n;
            acc            <= '0;
            channel_output <= '0;
        end else begin
            prev_p <= counter_p;
            prev_n <= counter_n;
            if (enable_sampling_3M) begin
                channel_output <= out_sat;
                acc            <= '0;
            end else begin
                acc <= sum_sat;
            end
        end
    end

endmodule

// File: tb/tb_vco_adc_decim_datapath.sv
// tb/tb_vco_adc_decim_datapath.sv - scoreboard bench for vco_adc_decim_datapath
module tb_vco_adc_decim_datapath;

    logic              CLK_24M = 1'b0;
    logic              reset = 1'b1;
    logic              enable_sampling_3M = 1'b0;
    logic        [8:0] counter_p = 9'd0;
    logic        [8:0] counter_n = 9'd0;
    logic signed [8:0] channel_output;

    int n_tests = 0;
    int n_fail  = 0;

    int win      = 0;
    int last_out = 0;
    int exp_q[$];

    vco_adc_decim_datapath #(.N_BITS_ACC_EXT(3)) dut (
        .CLK_24M            (CLK_24M),
        .reset              (reset),
        .enable_sampling_3M (enable_sampling_3M),
        .counter_p          (counter_p),
        .counter_n          (counter_n),
        .channel_output     (channel_output)
    );

    always #20 CLK_24M = ~CLK_24M;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic check(input string tag, input int expv);
        n_tests++;
        assert (channel_output === 9'(expv)) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, channel_output, expv);
        end
    endtask

    // One normal cycle: advance counters, optionally strobe, then check after the edge
    task automatic step(input int ip, input int in_, input bit stb, input string tag);
        int expv;
        counter_p          = 9'((int'(counter_p) + ip) % 512);
        counter_n          = 9'((int'(counter_n) + in_) % 512);
        enable_sampling_3M = stb;
        reset              = 1'b0;
        win = clamp(win + ip - in_, -4096, 4095);
        if (stb) begin
            exp_q.push_back(clamp(win, -256, 255));
            win = 0;
        end
        @(posedge CLK_24M);
        #1;
        if (stb) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s scoreboard empty", tag);
            end else begin
                expv = exp_q.pop_front();
                last_out = expv;
                check(tag, expv);
            end
        end else begin
            check({tag, "_hold"}, last_out);
        end
    endtask

    // One reset cycle: counters keep moving, state is cleared
    task automatic rst_step(input int ip, input int in_, input bit stb);
        counter_p          = 9'((int'(counter_p) + ip) % 512);
        counter_n          = 9'((int'(counter_n) + in_) % 512);
        enable_sampling_3M = stb;
        reset              = 1'b1;
        @(posedge CLK_24M);
        #1;
        win = 0;
        last_out = 0;
        check("reset", 0);
    endtask

    task automatic windows(input int ip, input int in_, input int n_win, input int len, input string tag);
        for (int w = 0; w < n_win; w++) begin
            for (int c = 0; c < len; c++) begin
                step(ip, in_, c == len - 1, tag);
            end
        end
    endtask

    initial begin
        counter_p = 9'd100;
        counter_n = 9'd100;
        rst_step(0, 0, 1'b1);
        rst_step(0, 0, 1'b0);

        // 1: frozen counters
        windows(0, 0, 3, 8, "frozen");

        // 2: rate difference, then swapped
        windows(10, 6, 3, 8, "p10n6");
        windows(6, 10, 3, 8, "p6n10");

        // 3: wrap through 511 -> 0
        counter_p = 9'd500;
        counter_n = 9'd0;
        rst_step(8, 8, 1'b0);
        windows(8, 8, 3, 8, "wrap");

        // 4: saturation both ways
        windows(60, 0, 2, 8, "sat_pos");
        windows(0, 60, 2, 8, "sat_neg");

        // 5: reset mid-window, then a 5-cycle window after release
        windows(10, 6, 1, 8, "pre_rst");
        for (int i = 0; i < 3; i++) step(10, 6, 1'b0, "mid_win");
        rst_step(10, 6, 1'b0);
        rst_step(10, 6, 1'b1);
        for (int i = 0; i < 5; i++) step(10, 6, i == 4, "post_rst");
        n_tests++;
        assert (last_out == 20) else begin
            n_fail++;
            $error("FAIL post_rst_value observed=%0d expected=%0d", channel_output, 20);
        end

        // 6: 4-cycle spacing, then back-to-back strobes
        windows(10, 6, 3, 4, "space4");
        windows(10, 6, 3, 1, "b2b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
